// File: rtl/axil_led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// axil_led_pwm_ctrl
//   AXI4-Lite slave driving NUM_LED LED outputs. Each channel runs in OFF, ON,
//   BLINK or PWM mode. All channels are timed from one shared programmable tick
//   prescaler.
//
//   Register map (byte offset, addr[7:0] decoded, addr[1:0] ignored):
//     0x00        CTRL      bit0 EN (RW), bit1 SYNC (write-1 pulse, reads 0)
//     0x04        INFO      RO {16'h4C45, 8'd0, NUM_LED[7:0]}
//     0x08        PRESCALE  [15:0] RW
//     0x10+4*n    CHn       [1:0] MODE, [15:8] DUTY, [23:16] PERIOD
//   Unmapped offsets answer SLVERR. Reads of unmapped offsets return 0, and
//   writes to them are discarded.
//
//   Ports:
//     sys_clk, rst_n      clock, asynchronous active-low reset
//     s_axil_aw*/w*/b*    AXI-Lite write address / data / response channels
//     s_axil_ar*/r*       AXI-Lite read address / data channels
//     LED                 registered LED drive, NUM_LED bits
//
//   Optional build macro LED_ACTIVE_LOW_EN:
//     When defined, LED is the inverse of the channel state. LED resets to all
//     ones, and EN=0 forces all ones.
// -----------------------------------------------------------------------------
module axil_led_pwm_ctrl #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 32,
    parameter int          STRB_WIDTH   = 4,
    parameter int          NUM_LED      = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd999
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [NUM_LED-1:0]    LED
);

    localparam int         CH_BASE     = 4;      // word index of CH0 (0x10)
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] MODE_ON     = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_PWM    = 2'd3;

    // Configuration registers
    logic        ctrl_en;
    logic [15:0] prescale;
    logic [1:0]  ch_mode   [NUM_LED];
    logic [7:0]  ch_duty   [NUM_LED];
    logic [7:0]  ch_period [NUM_LED];

    // Protection bits, upper address bits and wdata[31:24] carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr,
                         s_axil_wdata};

    // ------------------------------------------------------------------
    // Write decode. awready is high only in the accept cycle, and the
    // master holds address/data stable until then, so the live bus values
    // are decoded directly.
    // ------------------------------------------------------------------
    logic [5:0]         wr_word;
    logic               wr_fire;
    logic               wr_ctrl, wr_info, wr_pre;
    logic [NUM_LED-1:0] wr_ch_hit;
    logic [NUM_LED-1:0] wr_ch;
    logic               wr_hit;
    logic               sync_clr;

    assign wr_word = s_axil_awaddr[7:2];
    assign wr_fire = s_axil_awready;

    always_comb begin
        wr_ch_hit = '0;
        for (int i = 0; i < NUM_LED; i++)
            wr_ch_hit[i] = (wr_word == 6'(CH_BASE + i));
    end

    assign wr_ctrl  = wr_fire && (wr_word == 6'd0);
    assign wr_info  = wr_fire && (wr_word == 6'd1);
    assign wr_pre   = wr_fire && (wr_word == 6'd2);
    assign wr_ch    = wr_fire ? wr_ch_hit : '0;
    assign wr_hit   = wr_ctrl || wr_info || wr_pre || (|wr_ch);
    assign sync_clr = wr_ctrl && s_axil_wstrb[0] && s_axil_wdata[1];

    // ------------------------------------------------------------------
    // Read decode. This uses the register values from before the current
    // edge, so a read that coincides with a write returns the old value.
    // ------------------------------------------------------------------
    logic [5:0]  rd_word;
    logic [31:0] rd_data_nxt;
    logic        rd_err_nxt;

    assign rd_word = s_axil_araddr[7:2];

    always_comb begin
        rd_data_nxt = '0;
        rd_err_nxt  = 1'b0;
        case (rd_word)
            6'd0:    rd_data_nxt = {31'd0, ctrl_en};
            6'd1:    rd_data_nxt = {16'h4C45, 8'd0, 8'(NUM_LED)};
            6'd2:    rd_data_nxt = {16'd0, prescale};
            default: rd_err_nxt  = 1'b1;
        endcase
        for (int i = 0; i < NUM_LED; i++) begin
            if (rd_word == 6'(CH_BASE + i)) begin
                rd_data_nxt = {8'd0, ch_period[i], ch_duty[i], 6'd0, ch_mode[i]};
                rd_err_nxt  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // AXI-Lite handshakes
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rdata   <= '0;
        end else begin
            if (s_axil_awready) begin
                s_axil_awready <= 1'b0;
                s_axil_wready  <= 1'b0;
                s_axil_bvalid  <= 1'b1;
                s_axil_bresp   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid) begin
                s_axil_awready <= 1'b1;
                s_axil_wready  <= 1'b1;
            end
            if (s_axil_bvalid && s_axil_bready)
                s_axil_bvalid <= 1'b0;

            if (s_axil_arready) begin
                s_axil_arready <= 1'b0;
                s_axil_rvalid  <= 1'b1;
                s_axil_rdata   <= rd_err_nxt ? '0 : rd_data_nxt;
                s_axil_rresp   <= rd_err_nxt ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_arvalid && !s_axil_rvalid) begin
                s_axil_arready <= 1'b1;
            end
            if (s_axil_rvalid && s_axil_rready)
                s_axil_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en  <= 1'b0;
            prescale <= PRESCALE_RST;
            for (int i = 0; i < NUM_LED; i++) begin
                ch_mode[i]   <= '0;
                ch_duty[i]   <= '0;
                ch_period[i] <= '0;
            end
        end else begin
            if (wr_ctrl && s_axil_wstrb[0])
                ctrl_en <= s_axil_wdata[0];
            if (wr_pre) begin
                if (s_axil_wstrb[0]) prescale[7:0]  <= s_axil_wdata[7:0];
                if (s_axil_wstrb[1]) prescale[15:8] <= s_axil_wdata[15:8];
            end
            for (int i = 0; i < NUM_LED; i++) begin
                if (wr_ch[i]) begin
                    if (s_axil_wstrb[0]) ch_mode[i]   <= s_axil_wdata[1:0];
                    if (s_axil_wstrb[1]) ch_duty[i]   <= s_axil_wdata[15:8];
                    if (s_axil_wstrb[2]) ch_period[i] <= s_axil_wdata[23:16];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick prescaler: counts 0..prescale and ticks on the wrap cycle.
    // ------------------------------------------------------------------
    logic [15:0] pre_cnt;
    logic        tick;

    assign tick = ctrl_en && (pre_cnt == prescale);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else if (!ctrl_en || wr_pre || sync_clr || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 16'd1;
    end

    // ------------------------------------------------------------------
    // Per-channel timing state
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0] chan_on;

    for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
        logic [7:0] cnt;
        logic [7:0] phase;
        logic       blink;

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                phase <= '0;
                blink <= 1'b0;
            end else if (!ctrl_en || sync_clr || wr_ch[g]) begin
                cnt   <= '0;
                phase <= '0;
                blink <= 1'b0;
            end else if (tick) begin
                if (ch_mode[g] == MODE_BLINK) begin
                    if (cnt == ch_period[g]) begin
                        cnt   <= '0;
                        blink <= ~blink;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else if (ch_mode[g] == MODE_PWM) begin
                    phase <= phase + 8'd1;
                end
            end
        end

        assign chan_on[g] = (ch_mode[g] == MODE_ON)
                         || ((ch_mode[g] == MODE_BLINK) && blink)
                         || ((ch_mode[g] == MODE_PWM) && (phase < ch_duty[g]));
    end

    // ------------------------------------------------------------------
    // LED output register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
`ifdef LED_ACTIVE_LOW_EN
        if (!rst_n)
            LED <= '1;
        else
            LED <= ctrl_en ? ~chan_on : '1;
`else
        if (!rst_n)
            LED <= '0;
        else
            LED <= ctrl_en ? chan_on : '0;
`endif
    end

endmodule

// File: tb/tb_axil_led_pwm_ctrl.sv
`timescale 1ns/1ps
module tb_axil_led_pwm_ctrl;

    localparam int NUM_LED = 8;

    logic               sys_clk = 1'b0;
    logic               rst_n   = 1'b0;
    logic [15:0]        s_axil_awaddr  = '0;
    logic [2:0]         s_axil_awprot  = '0;
    logic               s_axil_awvalid = 1'b0;
    logic               s_axil_awready;
    logic [31:0]        s_axil_wdata   = '0;
    logic [3:0]         s_axil_wstrb   = '0;
    logic               s_axil_wvalid  = 1'b0;
    logic               s_axil_wready;
    logic [1:0]         s_axil_bresp;
    logic               s_axil_bvalid;
    logic               s_axil_bready  = 1'b1;
    logic [15:0]        s_axil_araddr  = '0;
    logic [2:0]         s_axil_arprot  = '0;
    logic               s_axil_arvalid = 1'b0;
    logic               s_axil_arready;
    logic [31:0]        s_axil_rdata;
    logic [1:0]         s_axil_rresp;
    logic               s_axil_rvalid;
    logic               s_axil_rready  = 1'b1;
    logic [NUM_LED-1:0] LED;

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    axil_led_pwm_ctrl #(.NUM_LED(NUM_LED)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .LED(LED)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the register contents as software sees them
    logic        m_en = 1'b0;
    logic [15:0] m_pre = 16'd999;
    logic [31:0] m_ch [NUM_LED];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic m_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
        logic [31:0] mk;
        int off;
        mk  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        off = int'(a[7:0]);
        r   = 2'b00;
        if (off == 0) begin
            if (s[0]) m_en = d[0];
        end else if (off == 4) begin
            r = 2'b00;
        end else if (off == 8) begin
            m_pre = (m_pre & ~mk[15:0]) | (d[15:0] & mk[15:0]);
        end else if (off >= 16 && off < 16 + 4 * NUM_LED && (off % 4) == 0) begin
            m_ch[(off - 16) / 4] = ((m_ch[(off - 16) / 4] & ~mk) | (d & mk)) & 32'h00FF_FF03;
        end else begin
            r = 2'b10;
        end
    endtask

    task automatic m_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
        int off;
        off = int'(a[7:0]);
        d = '0;
        r = 2'b00;
        if (off == 0)      d = {31'd0, m_en};
        else if (off == 4) d = 32'h4C45_0000 | 32'(NUM_LED);
        else if (off == 8) d = {16'd0, m_pre};
        else if (off >= 16 && off < 16 + 4 * NUM_LED && (off % 4) == 0) d = m_ch[(off - 16) / 4];
        else r = 2'b10;
    endtask

    // Expected LED in cycle c (c >= 1) after a synchronising edge.
    // With a prescaler of Q, floor(k/(Q+1)) ticks have occurred before cycle k.
    // LED in cycle c shows the channel state of cycle c-1.
    function automatic logic [NUM_LED-1:0] exp_led(input int c);
        int n, md, du, pe;
        logic [NUM_LED-1:0] v;
        v = '0;
        if (!m_en) return v;
        n = (c - 1) / (int'(m_pre) + 1);
        for (int i = 0; i < NUM_LED; i++) begin
            md = int'(m_ch[i][1:0]);
            du = int'(m_ch[i][15:8]);
            pe = int'(m_ch[i][23:16]);
            case (md)
                1:       v[i] = 1'b1;
                2:       v[i] = ((n / (pe + 1)) % 2) == 1;
                3:       v[i] = (n % 256) < du;
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic wait_aw();
        int k;
        k = 0;
        do begin tick_wait(); k++; end while (!(s_axil_awready && s_axil_wready) && k < 20);
        chk("wr_accept", {31'd0, s_axil_awready & s_axil_wready}, 32'd1);
    endtask

    // Returns in cycle T+1 with t_edge = cycle count of the edge ending T.
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int t_edge);
        logic [1:0] er;
        m_write(a, d, s, er);
        s_axil_awaddr  = a;
        s_axil_wdata   = d;
        s_axil_wstrb   = s;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        wait_aw();
        tick_wait();
        t_edge = cyc;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        chk("bvalid", {31'd0, s_axil_bvalid}, 32'd1);
        chk("bresp", {30'd0, s_axil_bresp}, {30'd0, er});
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
        int k;
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        k = 0;
        do begin tick_wait(); k++; end while (!s_axil_arready && k < 20);
        chk("rd_accept", {31'd0, s_axil_arready}, 32'd1);
        tick_wait();
        s_axil_arvalid = 1'b0;
        chk("rvalid", {31'd0, s_axil_rvalid}, 32'd1);
        d = s_axil_rdata;
        r = s_axil_rresp;
    endtask

    task automatic rd_chk(input logic [15:0] a);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        m_read(a, ed, er);
        axi_read(a, d, r);
        chk($sformatf("rdata@%h", a), d, ed);
        chk($sformatf("rresp@%h", a), {30'd0, r}, {30'd0, er});
    endtask

    task automatic run_model(input int s_edge, input int ncyc, input string tag,
                             input int bit_sel, output int ones);
        ones = 0;
        for (int k = 0; k < ncyc; k++) begin
            tick_wait();
            chk(tag, {24'd0, LED}, {24'd0, exp_led(cyc - s_edge)});
            ones += int'(LED[bit_sel]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ones, p;
        logic [31:0] d;
        logic [1:0]  er;

        for (int i = 0; i < NUM_LED; i++) m_ch[i] = '0;

        // Reset
        repeat (3) tick_wait();
        rst_n = 1'b1;
        tick_wait();
        chk("rst_awready", {31'd0, s_axil_awready}, 32'd0);
        chk("rst_arready", {31'd0, s_axil_arready}, 32'd0);
        chk("rst_bvalid",  {31'd0, s_axil_bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, s_axil_rvalid},  32'd0);
        chk("rst_led",     {24'd0, LED},            32'd0);
        rd_chk(16'h04);
        rd_chk(16'h08);
        rd_chk(16'h00);
        rd_chk(16'h10);

        // EN, then CH0 ON: LED[0] rises at T+2
        axi_write(16'h00, 32'h1, 4'hF, t);
        axi_write(16'h10, 32'h1, 4'hF, t);
        chk("led_t1", {24'd0, LED}, 32'h00);
        tick_wait();
        chk("led_t2", {24'd0, LED}, 32'h01);

        // PRESCALE=0, CH1 BLINK PERIOD=3, synchronise
        axi_write(16'h08, 32'h0, 4'hF, t);
        axi_write(16'h14, 32'h0003_0002, 4'hF, t);
        axi_write(16'h00, 32'h3, 4'hF, t);
        run_model(t, 40, "blink1", 1, ones);
        chk("blink1_ones", ones, 32'd20);

        // bvalid held by bready=0 blocks a second write
        s_axil_bready = 1'b0;
        m_write(16'h1C, 32'h1, 4'hF, er);
        s_axil_awaddr = 16'h1C; s_axil_wdata = 32'h1; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        wait_aw();
        tick_wait();
        s_axil_awaddr = 16'h20;
        for (int k = 0; k < 6; k++) begin
            chk("hold_bvalid",  {31'd0, s_axil_bvalid},  32'd1);
            chk("hold_awready", {31'd0, s_axil_awready}, 32'd0);
            tick_wait();
        end
        s_axil_bready = 1'b1;
        m_write(16'h20, 32'h1, 4'hF, er);
        wait_aw();
        tick_wait();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        chk("second_bvalid", {31'd0, s_axil_bvalid}, 32'd1);
        chk("second_bresp",  {30'd0, s_axil_bresp},  32'd0);
        rd_chk(16'h1C);
        rd_chk(16'h20);

        // PWM DUTY=64 then DUTY=0
        axi_write(16'h18, 32'h0000_4003, 4'hF, t);
        axi_write(16'h00, 32'h3, 4'hF, t);
        run_model(t, 256, "pwm64", 2, ones);
        chk("pwm64_ones", ones, 32'd64);
        axi_write(16'h18, 32'h0000_0003, 4'hF, t);
        axi_write(16'h00, 32'h3, 4'hF, t);
        run_model(t, 260, "pwm0", 2, ones);
        chk("pwm0_ones", ones, 32'd0);

        // Error responses and ignored writes
        axi_write(16'h30, 32'hFFFF_FFFF, 4'hF, t);
        axi_write(16'h0C, 32'hFFFF_FFFF, 4'hF, t);
        axi_write(16'h04, 32'hFFFF_FFFF, 4'hF, t);
        rd_chk(16'h30);
        rd_chk(16'h0C);
        rd_chk(16'h04);
        for (int i = 0; i < NUM_LED; i++) rd_chk(16'(16 + 4 * i));

        // Partial strobes
        axi_write(16'h24, 32'hAABB_CC02, 4'b0010, t);
        rd_chk(16'h24);
        axi_write(16'h08, 32'h0000_1234, 4'b0001, t);
        rd_chk(16'h08);
        axi_write(16'h08, 32'h0, 4'hF, t);

        // CH0..3 BLINK with mixed phases, then SYNC brings them into lockstep
        p = $urandom_range(1, 4);
        for (int i = 0; i < 4; i++) begin
            axi_write(16'(16 + 4 * i), {8'd0, 8'(p), 16'h0002}, 4'hF, t);
            repeat (3) tick_wait();
        end
        axi_write(16'h00, 32'h3, 4'hF, t);
        run_model(t, 40, "lockstep", 0, ones);
        axi_write(16'h00, 32'h0, 4'hF, t);
        run_model(t, 10, "en_off", 0, ones);
        chk("en_off_ones", ones, 32'd0);

        // Randomised configurations checked against the model
        for (int it = 0; it < 8; it++) begin
            d = $urandom;
            d[15:0] = 16'($urandom_range(0, 3));
            axi_write(16'h08, d, 4'hF, t);
            for (int i = 0; i < NUM_LED; i++) begin
                d = $urandom;
                d[23:16] = 8'($urandom_range(0, 7));
                axi_write(16'(16 + 4 * i), d, 4'($urandom_range(0, 15)), t);
            end
            rd_chk(16'(16 + 4 * $urandom_range(0, NUM_LED - 1)));
            rd_chk(16'h08);
            d = $urandom;
            d[1] = 1'b1;
            if (it == 0) d[0] = 1'b1;
            axi_write(16'h00, d, 4'hF, t);
            run_model(t, 50, "random", 0, ones);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_led_pwm_ctrl.md
Name: axil_led_pwm_ctrl

Overview:
- Parametrised AXI4-Lite LED controller; successor to the single 8-bit LED register block.
- Drives NUM_LED outputs. Each channel is independently set to OFF, ON, BLINK or PWM, all timed from a shared programmable tick prescaler.
- Sits as a leaf slave on the AXI-Lite interconnect.
- Contains its own AXI-Lite handshake logic; no external register-interface adapter.

Parameters:
- ADDR_WIDTH, 16, AXI-Lite address width; only addr[7:0] is decoded.
- DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- STRB_WIDTH, 4, write strobe width (DATA_WIDTH/8).
- NUM_LED, 8, number of LED channels, 1..16.
- PRESCALE_RST, 16'd999, reset value of the PRESCALE register.

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_axil_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; awprot ignored
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write data channel
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axil_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel; arprot ignored
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- LED  out  NUM_LED  LED drive, registered

Behaviour:
- Reset (async on rst_n low):
  - all ready/valid outputs 0; bresp, rresp, rdata 0.
  - CTRL=0, PRESCALE=PRESCALE_RST, all CHn=0, all counters 0, LED all 0.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 EN (RW); bit1 SYNC (write-1 self-clearing, reads 0).
  - 0x04 INFO: RO = {16'h4C45, 8'd0, NUM_LED[7:0]}; writes ignored, OKAY.
  - 0x08 PRESCALE: [15:0] RW.
  - 0x10+4*n CHn: [1:0] MODE (0 OFF, 1 ON, 2 BLINK, 3 PWM), [15:8] DUTY, [23:16] PERIOD; other bits read 0.
- Error response: offsets outside the map (including CHn with n>=NUM_LED) return SLVERR; read data 0; write discarded.
- Write handshake:
  - Accept only when awvalid && wvalid && !bvalid; awready and wready pulse together for exactly 1 cycle (cycle T).
  - Register updates at the edge ending T; bvalid asserts at T+1 and holds until bready.
  - No further write accepted while bvalid=1.
  - wstrb applied per byte; a byte with strb=0 is unchanged.
- Read handshake:
  - arready pulses 1 cycle when arvalid && !rvalid.
  - rvalid+rdata at the next cycle, held stable until rready.
- Read and write channels are independent. A same-cycle read of a register being written returns the old value.
- Tick prescaler:
  - Counter counts 0..PRESCALE; tick=1 on the wrap cycle. PRESCALE=0 gives tick every cycle.
  - Any PRESCALE write clears the counter.
- Channel n, advancing on tick only:
  - BLINK: cnt counts 0..PERIOD; on wrap, state toggles. PERIOD=0 toggles every tick.
  - PWM: 8-bit phase increments, wrapping 255->0; on = (phase < DUTY). DUTY=0 never on; DUTY=255 gives 255/256.
  - OFF: 0. ON: 1.
- Any write to CHn (any strobe) clears that channel's cnt, phase and blink state (state=off).
- EN=0: prescaler and all channel counters held at 0; LED forced 0; register access unaffected.
- SYNC=1 write: prescaler and all channel counters/states clear in the same edge. If the same write changes EN or PRESCALE, the new values also take effect on that edge.
- LED is registered from channel state: a write at T takes effect on LED at T+2.
- Reset asserted mid-transaction aborts it; no response is issued after release.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
- Defined: LED = ~channel state; reset value all 1s; EN=0 forces LED all 1s.
- Undefined: active-high as specified above.

Test Plan:
- Reset, then read 0x04 with NUM_LED=8 -> rdata 32'h4C45_0008, rresp 0; read 0x08 -> 999.
- Write 0x00=1, 0x10=32'h1 (handshake at T) -> bvalid at T+1; LED[0]=1 at T+2; other LEDs 0.
- PRESCALE=0, CH1=BLINK with PERIOD=3 -> LED[1] toggles every 4 cycles; holding bready=0 keeps bvalid high and blocks a second write.
- PRESCALE=0, CH2=PWM with DUTY=64 -> LED[2] high 64 of every 256 cycles; DUTY=0 -> constant 0.
- Write to 0x30 with NUM_LED=8 -> bresp 2'b10, no state change; read 0x30 -> rresp 2'b10, rdata 0.
- CH0..CH3 BLINK with mixed phases, then write CTRL=32'h3 -> all four LEDs 0 at the next update, then toggle in lockstep; write CTRL=0 -> LED all 0.
